// File: rtl/bank_fifo.sv
// Two-bank ping-pong word FIFO: the writer fills one bank while the reader drains the other.
// Optional status outputs (full_banks, w_overflow) are enabled by defining BANK_FIFO_STATUS_EN.
module bank_fifo #(
   parameter int W = 16,
   parameter int N = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         w_trigger,
   input  logic [W-1:0] w_data,
   output logic         w_done,
   input  logic         r_trigger,
   output logic [W-1:0] r_data,
   output logic         r_done
`ifdef BANK_FIFO_STATUS_EN
   ,
   output logic [1:0]   full_banks,
   output logic         w_overflow
`endif
);

   localparam int           DEPTH    = 2 ** (N + 1);
   localparam logic [N-1:0] ADDR_ONE = {{(N - 1) {1'b0}}, 1'b1};

   logic [W-1:0] r_mem [DEPTH];
   logic         r_w_bank;
   logic [N-1:0] r_w_addr;
   logic         r_rd_bank;
   logic [N-1:0] r_rd_addr;
   logic [1:0]   r_full;
   logic [W-1:0] r_rdata;
   logic         r_rdone;

   logic         w_rd;
   logic         w_w_last;
   logic         w_r_last;
   logic [1:0]   w_full_nxt;

   // Writer and reader can never target the same bank: one needs it empty, the other full.
   assign w_done   = w_trigger & ~r_full[r_w_bank];
   assign w_rd     = r_trigger & r_full[r_rd_bank];
   assign w_w_last = &r_w_addr;
   assign w_r_last = &r_rd_addr;

   always_comb begin
      // NOTE: default assigned first so every path drives the signal and no latch is inferred.
      w_full_nxt = r_full;
      if (w_done && w_w_last) w_full_nxt[r_w_bank] = 1'b1;
      if (w_rd && w_r_last)   w_full_nxt[r_rd_bank] = 1'b0;
   end

   // NOTE: the storage array is deliberately not reset; only control state is cleared, which
   // keeps it mappable onto block RAM. Stale words are unreachable because the flags are cleared.
   always_ff @(posedge clk) begin
      if (w_done) r_mem[{r_w_bank, r_w_addr}] <= w_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_w_bank  <= 1'b0;
         r_w_addr  <= '0;
         r_rd_bank <= 1'b0;
         r_rd_addr <= '0;
         r_full    <= 2'b00;
         r_rdata   <= '0;
         r_rdone   <= 1'b0;
      end else begin
         r_full  <= w_full_nxt;
         r_rdone <= w_rd;
         if (w_done) begin
            r_w_addr <= r_w_addr + ADDR_ONE;
            if (w_w_last) r_w_bank <= ~r_w_bank;
         end
         if (w_rd) begin
            r_rdata   <= r_mem[{r_rd_bank, r_rd_addr}];
            r_rd_addr <= r_rd_addr + ADDR_ONE;
            if (w_r_last) r_rd_bank <= ~r_rd_bank;
         end
      end
   end

   assign r_data = r_rdata;
   assign r_done = r_rdone;

`ifdef BANK_FIFO_STATUS_EN
   logic [1:0] r_full_banks;
   logic       r_overflow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full_banks <= 2'd0;
         r_overflow   <= 1'b0;
      end else begin
         r_full_banks <= {1'b0, w_full_nxt[0]} + {1'b0, w_full_nxt[1]};
         if (w_trigger && !w_done) r_overflow <= 1'b1;
      end
   end

   assign full_banks = r_full_banks;
   assign w_overflow = r_overflow;
`endif

endmodule

// File: tb/tb_bank_fifo.sv
// Self-checking bench for bank_fifo: scoreboard queue of accepted words plus an occupancy model
// derived from total write/read counts. Define BANK_FIFO_STATUS_EN to also check the status outputs.
module tb_bank_fifo;

   localparam int W    = 16;
   localparam int N    = 7;
   localparam int BANK = 1 << N;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         w_trigger = 1'b0;
   logic [W-1:0] w_data = '0;
   logic         w_done;
   logic         r_trigger = 1'b0;
   logic [W-1:0] r_data;
   logic         r_done;
`ifdef BANK_FIFO_STATUS_EN
   logic [1:0]   full_banks;
   logic         w_overflow;
`endif

   bank_fifo #(.W(W), .N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .w_trigger  (w_trigger),
      .w_data     (w_data),
      .w_done     (w_done),
      .r_trigger  (r_trigger),
      .r_data     (r_data),
      .r_done     (r_done)
`ifdef BANK_FIFO_STATUS_EN
      ,
      .full_banks (full_banks),
      .w_overflow (w_overflow)
`endif
   );

   always #5 clk = ~clk;

   int           checks = 0;
   int           failures = 0;
   logic [W-1:0] sb_q[$];
   int           wcnt, rcnt, cyc;
   int           acc_last_cyc, first_rd_cyc;
   logic [W-1:0] first_rd_data;
   bit           pend_rd, ovf, prev_rt, seen_rd;
   logic [W-1:0] next_wdata;
   int           phase_wd, phase_rd, wd_resume_cyc, rd128_cyc;
   logic [W-1:0] last_rd;
   bit           last_rd_valid, saw_wrap;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Banks completely written minus banks completely read = banks currently full.
   function automatic int fbanks();
      return wcnt / BANK - rcnt / BANK;
   endfunction

   task automatic model_reset(input logic [W-1:0] start);
      sb_q.delete();
      wcnt = 0; rcnt = 0;
      pend_rd = 1'b0; ovf = 1'b0; prev_rt = 1'b0; seen_rd = 1'b0;
      acc_last_cyc = -100; first_rd_cyc = -1; first_rd_data = '1;
      next_wdata = start;
      last_rd_valid = 1'b0;
   endtask

   // One clock: check outputs of the previous edge, then drive inputs for the next edge.
   task automatic cycle(input bit wt, input bit rt);
      logic [W-1:0] exp_d;
      bit           exp_wd;
      int           fb;
      @(negedge clk);
      cyc++;
      check("r_done", r_done, pend_rd);
      check("r_done_without_trigger", r_done & ~prev_rt, 1'b0);
      if (r_done === 1'b1) begin
         phase_rd++;
         if (phase_rd == BANK) rd128_cyc = cyc;
         if (last_rd_valid && last_rd == 16'hFFFF && r_data == 16'h0000) saw_wrap = 1'b1;
         last_rd = r_data;
         last_rd_valid = 1'b1;
      end
      if (pend_rd) begin
         if (sb_q.size() == 0) check("scoreboard_empty", 1, 0);
         else begin
            exp_d = sb_q.pop_front();
            check("r_data", r_data, exp_d);
         end
         if (!seen_rd) begin
            seen_rd = 1'b1;
            first_rd_cyc = cyc;
            first_rd_data = r_data;
         end
      end
`ifdef BANK_FIFO_STATUS_EN
      check("full_banks", full_banks, fbanks());
      check("w_overflow", w_overflow, ovf);
`endif
      w_trigger = wt;
      r_trigger = rt;
      w_data    = next_wdata;
      #1;
      fb     = fbanks();
      exp_wd = wt && (fb < 2);
      check("w_done", w_done, exp_wd);
      if (w_done === 1'b1) begin
         if (phase_wd == 0) wd_resume_cyc = cyc;
         phase_wd++;
      end
      if (wt && !exp_wd) ovf = 1'b1;
      if (exp_wd) begin
         sb_q.push_back(next_wdata);
         wcnt++;
         if (wcnt == BANK) acc_last_cyc = cyc;
         next_wdata = next_wdata + 16'd1;
      end
      pend_rd = rt && (fb > 0);
      if (pend_rd) rcnt++;
      prev_rt = rt;
   endtask

   // Asserts reset between clock edges, checks the cleared outputs, releases on a falling edge.
   task automatic do_reset(input logic [W-1:0] start);
      #2;
      rst_n     = 1'b0;
      w_trigger = 1'b0;
      r_trigger = 1'b0;
      #1;
      check("rst_r_done", r_done, 1'b0);
      check("rst_r_data", r_data, '0);
      check("rst_w_done", w_done, 1'b0);
`ifdef BANK_FIFO_STATUS_EN
      check("rst_full_banks", full_banks, 2'd0);
      check("rst_w_overflow", w_overflow, 1'b0);
`endif
      model_reset(start);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      cyc = 0;
      model_reset('0);
      do_reset(16'h0000);

      // Continuous stream with both triggers held high.
      repeat (1200) cycle(1'b1, 1'b1);
      check("first_rd_latency", first_rd_cyc - acc_last_cyc, 2);
      check("first_rd_data", first_rd_data, 16'h0000);

      // Back-pressure: reader idle, writer fills both banks and stalls.
      do_reset(16'h0000);
      phase_wd = 0;
      repeat (300) cycle(1'b1, 1'b0);
      check("bp_w_done_pulses", phase_wd, 256);
      phase_wd = 0; phase_rd = 0; wd_resume_cyc = -1; rd128_cyc = -1000;
      repeat (200) cycle(1'b1, 1'b1);
      check("bp_resume_within_2", (wd_resume_cyc >= rd128_cyc) && (wd_resume_cyc - rd128_cyc <= 2), 1'b1);

      // Bursty reader against a streaming writer.
      repeat (1500) cycle(1'b1, 1'($urandom_range(0, 1)));

      // Data wrap through 0xFFFF -> 0x0000.
      do_reset(16'hFF00);
      saw_wrap = 1'b0;
      repeat (700) cycle(1'b1, 1'b1);
      check("data_wrap_seen", saw_wrap, 1'b1);

      // Mid-stream asynchronous reset after 200 writes.
      do_reset(16'h0000);
      for (int i = 0; i < 1000 && wcnt < 200; i++) cycle(1'b1, 1'b1);
      check("pre_reset_reading", r_done, 1'b1);
      do_reset(16'h0000);
      repeat (400) cycle(1'b1, 1'b1);
      check("rst_first_rd_latency", first_rd_cyc - acc_last_cyc, 2);
      check("rst_first_rd_data", first_rd_data, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
